prf_operand_collector: RTL and testbench



---
 rtl/prf_operand_collector.sv | 134 +++++++++++++
 tb/tb_prf_operand_collector.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prf_operand_collector.sv
// prf_operand_collector: gathers two source operands for one issued op from PRF reads or the writeback bus
module prf_operand_collector #(
    parameter int LOG_PR_COUNT       = 7,
    parameter int PRF_BANK_COUNT     = 4,
    parameter int LOG_PRF_BANK_COUNT = 2,
    parameter int LOG_ROB_ENTRIES    = 7
) (
    input  logic                                                            CLK,
    input  logic                                                            nRST,
    input  logic                                                            in_valid,
    output logic                                                            in_ready,
    input  logic                                                            in_A_needed,
    input  logic                                                            in_B_needed,
    input  logic [LOG_PR_COUNT-1:0]                                         in_A_PR,
    input  logic [LOG_PR_COUNT-1:0]                                         in_B_PR,
    input  logic                                                            in_A_ready,
    input  logic                                                            in_B_ready,
    input  logic [LOG_ROB_ENTRIES-1:0]                                      in_ROB_index,
    input  logic                                                            flush,
    output logic                                                            reg_read_req_valid_A,
    output logic                                                            reg_read_req_valid_B,
    output logic [LOG_PR_COUNT-1:0]                                         reg_read_req_PR_A,
    output logic [LOG_PR_COUNT-1:0]                                         reg_read_req_PR_B,
    input  logic                                                            reg_read_ack_A,
    input  logic                                                            reg_read_ack_B,
    input  logic                                                            reg_read_port_A,
    input  logic                                                            reg_read_port_B,
    input  logic [PRF_BANK_COUNT-1:0][1:0][31:0]                            reg_read_data_by_bank_by_port,
    input  logic [PRF_BANK_COUNT-1:0]                                       WB_bus_valid_by_bank,
    input  logic [PRF_BANK_COUNT-1:0][31:0]                                 WB_bus_data_by_bank,
    input  logic [PRF_BANK_COUNT-1:0][LOG_PR_COUNT-LOG_PRF_BANK_COUNT-1:0]  WB_bus_upper_PR_by_bank,
    output logic                                                            out_valid,
    input  logic                                                            out_ready,
    output logic [31:0]                                                     out_A_data,
    output logic [31:0]                                                     out_B_data,
    output logic [LOG_ROB_ENTRIES-1:0]                                      out_ROB_index
);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COLLECT = 2'd1;
    localparam logic [1:0] S_OUTPUT  = 2'd2;
    localparam logic [1:0] O_DONE    = 2'd0;
    localparam logic [1:0] O_WAIT_WB = 2'd1;
    localparam logic [1:0] O_REQ     = 2'd2;
    localparam logic [1:0] O_RESP    = 2'd3;

    logic [1:0]                          r_state;
    logic [1:0]                          w_state_next;
    logic [1:0][1:0]                     r_op_st;
    logic [1:0][1:0]                     w_op_st_next;
    logic [1:0][LOG_PR_COUNT-1:0]        r_pr;
    logic [1:0][31:0]                    r_data;
    logic [1:0][31:0]                    w_data_next;
    logic [LOG_ROB_ENTRIES-1:0]          r_rob;
    logic                                w_accept;
    logic                                w_all_done;
    logic [1:0]                          w_need;
    logic [1:0]                          w_rdy;
    logic [1:0]                          w_ack;
    logic [1:0]                          w_port;
    logic [1:0][LOG_PR_COUNT-1:0]        w_in_pr;
    logic [1:0][LOG_PR_COUNT-1:0]        w_pr;
    logic [1:0][LOG_PRF_BANK_COUNT-1:0]  w_bank;
    logic [1:0]                          w_wb_hit;

    assign w_accept = (r_state == S_IDLE) && in_valid;
    assign w_need   = {in_B_needed, in_A_needed};
    assign w_rdy    = {in_B_ready, in_A_ready};
    assign w_ack    = {reg_read_ack_B, reg_read_ack_A};
    assign w_port   = {reg_read_port_B, reg_read_port_A};
    assign w_in_pr  = {in_B_PR, in_A_PR};

    assign in_ready             = (r_state == S_IDLE);
    assign out_valid            = (r_state == S_OUTPUT);
    assign reg_read_req_valid_A = (r_op_st[0] == O_REQ);
    assign reg_read_req_valid_B = (r_op_st[1] == O_REQ);
    assign reg_read_req_PR_A    = r_pr[0];
    assign reg_read_req_PR_B    = r_pr[1];
    assign out_A_data           = r_data[0];
    assign out_B_data           = r_data[1];
    assign out_ROB_index        = r_rob;

    // Per-operand progress: bus snoop (on the incoming PR while accepting), request/response, capture
    always_comb begin
        w_pr         = '0;
        w_bank       = '0;
        w_wb_hit     = '0;
        w_op_st_next = r_op_st;
        w_data_next  = r_data;
        for (int i = 0; i < 2; i++) begin
            w_pr[i]     = w_accept ? w_in_pr[i] : r_pr[i];
            w_bank[i]   = w_pr[i][LOG_PRF_BANK_COUNT-1:0];
            w_wb_hit[i] = WB_bus_valid_by_bank[w_bank[i]] &&
                          (WB_bus_upper_PR_by_bank[w_bank[i]] == w_pr[i][LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT]);
            if (w_accept) begin
                w_op_st_next[i] = !w_need[i] ? O_DONE : w_rdy[i] ? O_REQ : w_wb_hit[i] ? O_DONE : O_WAIT_WB;
                w_data_next[i]  = !w_need[i] ? '0 : (!w_rdy[i] && w_wb_hit[i]) ? WB_bus_data_by_bank[w_bank[i]] : r_data[i];
            end else if (r_op_st[i] == O_WAIT_WB) begin
                w_op_st_next[i] = w_wb_hit[i] ? O_DONE : O_WAIT_WB;
                w_data_next[i]  = w_wb_hit[i] ? WB_bus_data_by_bank[w_bank[i]] : r_data[i];
            end else if (r_op_st[i] == O_REQ) begin
                w_op_st_next[i] = O_RESP;
            end else if (r_op_st[i] == O_RESP) begin
                w_op_st_next[i] = w_ack[i] ? O_DONE : O_REQ;
                w_data_next[i]  = w_ack[i] ? reg_read_data_by_bank_by_port[w_bank[i]][w_port[i]] : r_data[i];
            end
        end
        w_all_done   = (w_op_st_next[0] == O_DONE) && (w_op_st_next[1] == O_DONE);
        w_state_next = (r_state == S_IDLE)    ? (in_valid ? (w_all_done ? S_OUTPUT : S_COLLECT) : S_IDLE) :
                       (r_state == S_COLLECT) ? (w_all_done ? S_OUTPUT : S_COLLECT) :
                       (out_ready ? S_IDLE : S_OUTPUT);
    end

    // State update; flush abandons the op and wins over accept and output fire
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state <= S_IDLE;
            r_op_st <= {O_DONE, O_DONE};
            r_pr    <= '0;
            r_data  <= '0;
            r_rob   <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_op_st <= {O_DONE, O_DONE};
        end else begin
            r_state <= w_state_next;
            r_op_st <= w_op_st_next;
            r_data  <= w_data_next;
            if (w_accept) begin
                r_pr  <= w_in_pr;
                r_rob <= in_ROB_index;
            end
        end
    end
endmodule

// File: tb/tb_prf_operand_collector.sv
// tb_prf_operand_collector: directed vectors, corner sequences and a randomized model check
module tb_prf_operand_collector;
    logic                  CLK = 1'b0;
    logic                  nRST = 1'b0;
    logic                  in_valid, in_ready;
    logic                  in_A_needed, in_B_needed, in_A_ready, in_B_ready;
    logic [6:0]            in_A_PR, in_B_PR, in_ROB_index;
    logic                  flush;
    logic                  reg_read_req_valid_A, reg_read_req_valid_B;
    logic [6:0]            reg_read_req_PR_A, reg_read_req_PR_B;
    logic                  reg_read_ack_A, reg_read_ack_B, reg_read_port_A, reg_read_port_B;
    logic [3:0][1:0][31:0] rd;
    logic [3:0]            wbv;
    logic [3:0][31:0]      wbd;
    logic [3:0][4:0]       wbu;
    logic                  out_valid, out_ready;
    logic [31:0]           out_A_data, out_B_data;
    logic [6:0]            out_ROB_index;

    int n_chk = 0;
    int n_pass = 0;

    always #5 CLK = ~CLK;

    prf_operand_collector dut (
        .CLK(CLK), .nRST(nRST),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_A_needed(in_A_needed), .in_B_needed(in_B_needed),
        .in_A_PR(in_A_PR), .in_B_PR(in_B_PR),
        .in_A_ready(in_A_ready), .in_B_ready(in_B_ready),
        .in_ROB_index(in_ROB_index), .flush(flush),
        .reg_read_req_valid_A(reg_read_req_valid_A), .reg_read_req_valid_B(reg_read_req_valid_B),
        .reg_read_req_PR_A(reg_read_req_PR_A), .reg_read_req_PR_B(reg_read_req_PR_B),
        .reg_read_ack_A(reg_read_ack_A), .reg_read_ack_B(reg_read_ack_B),
        .reg_read_port_A(reg_read_port_A), .reg_read_port_B(reg_read_port_B),
        .reg_read_data_by_bank_by_port(rd),
        .WB_bus_valid_by_bank(wbv), .WB_bus_data_by_bank(wbd), .WB_bus_upper_PR_by_bank(wbu),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_A_data(out_A_data), .out_B_data(out_B_data), .out_ROB_index(out_ROB_index)
    );

    typedef struct {
        logic             an;
        logic [6:0]       ap;
        logic             bn;
        logic [6:0]       bp;
        logic [6:0]       rob;
        logic [3:0]       v;
        logic [3:0][4:0]  u;
        logic [3:0][31:0] d;
        logic             exp_ov;
        logic [31:0]      ea;
        logic [31:0]      eb;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", nm, act, exp);
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic clr;
        in_valid = 0; in_A_needed = 0; in_B_needed = 0; in_A_ready = 0; in_B_ready = 0;
        in_A_PR = 0; in_B_PR = 0; in_ROB_index = 0; flush = 0; out_ready = 0;
        reg_read_ack_A = 0; reg_read_ack_B = 0; reg_read_port_A = 0; reg_read_port_B = 0;
        wbv = 0; wbd = 0; wbu = 0;
        for (int b = 0; b < 4; b++)
            for (int p = 0; p < 2; p++) rd[b][p] = 32'hA000_0000 | 32'(b * 16 + p);
    endtask

    task automatic issue(input logic an, input logic ar, input logic [6:0] ap,
                         input logic bn, input logic br, input logic [6:0] bp, input logic [6:0] rob);
        in_valid = 1; in_A_needed = an; in_A_ready = ar; in_A_PR = ap;
        in_B_needed = bn; in_B_ready = br; in_B_PR = bp; in_ROB_index = rob;
    endtask

    function automatic logic hit(input logic [6:0] p);
        return wbv[p[1:0]] && (wbu[p[1:0]] == p[6:2]);
    endfunction

    // reference model state for the randomized phase
    logic            m_busy, m_out;
    logic [1:0]      m_need, m_rdy, m_got, m_req, m_resp, ack, port;
    logic [1:0][6:0] m_pr;
    logic [1:0][31:0] m_val;
    logic [6:0]      m_rob, p;
    logic            sel, nreq;

    initial begin
        clr;
        tick;
        tick;
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_req_A", reg_read_req_valid_A, 1'b0);
        chk1("rst_req_B", reg_read_req_valid_B, 1'b0);
        chk("rst_req_PR_A", 32'(reg_read_req_PR_A), 0);
        chk("rst_out_A", out_A_data, 0);
        chk("rst_out_rob", 32'(out_ROB_index), 0);
        nRST = 1;

        // single-cycle outcomes decided at accept (operands not-ready or unused)
        tbl[0] = '{1'b0, 7'h00, 1'b0, 7'h00, 7'h01, 4'hF, {5'h1F, 5'h1F, 5'h1F, 5'h1F}, {4{32'hFFFF_FFFF}}, 1'b1, 32'h0, 32'h0};
        tbl[1] = '{1'b1, 7'h40, 1'b0, 7'h00, 7'h02, 4'b0001, {5'h0, 5'h0, 5'h0, 5'h10}, {32'h0, 32'h0, 32'h0, 32'h1111_2222}, 1'b1, 32'h1111_2222, 32'h0};
        tbl[2] = '{1'b1, 7'h40, 1'b0, 7'h00, 7'h03, 4'b0001, {5'h0, 5'h0, 5'h0, 5'h11}, {32'h0, 32'h0, 32'h0, 32'h1111_2222}, 1'b0, 32'h0, 32'h0};
        tbl[3] = '{1'b1, 7'h25, 1'b1, 7'h13, 7'h04, 4'b1010, {5'h04, 5'h0, 5'h09, 5'h0}, {32'hBBBB_0003, 32'h0, 32'hAAAA_0001, 32'h0}, 1'b1, 32'hAAAA_0001, 32'hBBBB_0003};
        tbl[4] = '{1'b1, 7'h25, 1'b1, 7'h13, 7'h05, 4'b1000, {5'h04, 5'h0, 5'h09, 5'h0}, {32'hBBBB_0003, 32'h0, 32'hAAAA_0001, 32'h0}, 1'b0, 32'h0, 32'h0};
        tbl[5] = '{1'b0, 7'h00, 1'b1, 7'h13, 7'h06, 4'b0111, {5'h04, 5'h04, 5'h04, 5'h04}, {32'h1, 32'h2, 32'h3, 32'h4}, 1'b0, 32'h0, 32'h0};
        tbl[6] = '{1'b1, 7'h7F, 1'b1, 7'h00, 7'h07, 4'b1001, {5'h1F, 5'h0, 5'h0, 5'h00}, {32'h7F7F_7F7F, 32'h5, 32'h6, 32'h0000_00AB}, 1'b1, 32'h7F7F_7F7F, 32'h0000_00AB};
        for (int i = 0; i < 7; i++) begin
            issue(tbl[i].an, 1'b0, tbl[i].ap, tbl[i].bn, 1'b0, tbl[i].bp, tbl[i].rob);
            wbv = tbl[i].v; wbu = tbl[i].u; wbd = tbl[i].d;
            tick;
            clr;
            chk1($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].exp_ov);
            if (tbl[i].exp_ov) begin
                chk($sformatf("vec%0d_A", i), out_A_data, tbl[i].ea);
                chk($sformatf("vec%0d_B", i), out_B_data, tbl[i].eb);
                chk($sformatf("vec%0d_rob", i), 32'(out_ROB_index), 32'(tbl[i].rob));
            end
            if (out_valid) out_ready = 1;
            else flush = 1;
            tick;
            clr;
            chk1($sformatf("vec%0d_idle", i), in_ready, 1'b1);
        end

        // ready operand, granted first time on port 1
        issue(1, 1, 7'h25, 0, 0, 7'h00, 7'h11);
        tick; clr;
        chk1("s1_req_c1", reg_read_req_valid_A, 1'b1);
        chk("s1_reqPR_c1", 32'(reg_read_req_PR_A), 32'h25);
        chk1("s1_reqB_c1", reg_read_req_valid_B, 1'b0);
        tick; clr;
        chk1("s1_req_c2", reg_read_req_valid_A, 1'b0);
        reg_read_ack_A = 1; reg_read_port_A = 1; rd[1][1] = 32'hDEAD_BEEF;
        tick; clr;
        chk1("s1_ov_c3", out_valid, 1'b1);
        chk("s1_A", out_A_data, 32'hDEAD_BEEF);
        chk("s1_B", out_B_data, 0);
        chk("s1_rob", 32'(out_ROB_index), 32'h11);
        out_ready = 1;
        tick; clr;
        chk1("s1_in_ready", in_ready, 1'b1);
        chk1("s1_ov_after", out_valid, 1'b0);

        // two nacks then a grant on port 0
        issue(1, 1, 7'h0E, 0, 0, 7'h00, 7'h22);
        for (int n = 0; n < 3; n++) begin
            tick; clr;
            chk1($sformatf("s2_req_%0d", n), reg_read_req_valid_A, 1'b1);
            tick; clr;
            chk1($sformatf("s2_noreq_%0d", n), reg_read_req_valid_A, 1'b0);
            chk1($sformatf("s2_ov_%0d", n), out_valid, 1'b0);
            reg_read_ack_A = (n == 2); reg_read_port_A = 0; rd[2][0] = 32'hCAFE_F00D;
        end
        tick; clr;
        chk1("s2_ov_c7", out_valid, 1'b1);
        chk("s2_A", out_A_data, 32'hCAFE_F00D);
        out_ready = 1;
        tick; clr;

        // writeback capture: wrong-upper and wrong-bank traffic ignored
        issue(0, 0, 7'h00, 1, 0, 7'h13, 7'h44);
        for (int c = 1; c <= 4; c++) begin
            tick; clr;
            chk1($sformatf("s3_reqB_c%0d", c), reg_read_req_valid_B, 1'b0);
            chk1($sformatf("s3_ov_c%0d", c), out_valid, 1'b0);
            if (c == 2) begin wbv = 4'b1100; wbu[3] = 5'h05; wbu[2] = 5'h04; wbd[3] = 32'hBAD; wbd[2] = 32'hBAD2; end
            if (c == 4) begin wbv[3] = 1; wbu[3] = 5'h04; wbd[3] = 32'h1234_5678; end
        end
        tick; clr;
        chk1("s3_ov_c5", out_valid, 1'b1);
        chk("s3_B", out_B_data, 32'h1234_5678);
        chk("s3_A", out_A_data, 0);
        out_ready = 1;
        tick; clr;

        // output back-pressure: data held while new traffic arrives
        issue(1, 0, 7'h40, 0, 0, 7'h00, 7'h33);
        wbv[0] = 1; wbu[0] = 5'h10; wbd[0] = 32'h55AA_55AA;
        tick; clr;
        chk1("s4_ov_c1", out_valid, 1'b1);
        for (int k = 0; k < 3; k++) begin
            issue(1, 0, 7'h40, 1, 0, 7'h00, 7'h7E);
            wbv = 4'hF; wbu[0] = 5'h10; wbd[0] = 32'h0BAD_BAD0;
            tick; clr;
            chk1($sformatf("s4_ov_hold%0d", k), out_valid, 1'b1);
            chk1($sformatf("s4_in_ready_hold%0d", k), in_ready, 1'b0);
            chk($sformatf("s4_A_hold%0d", k), out_A_data, 32'h55AA_55AA);
            chk($sformatf("s4_rob_hold%0d", k), 32'(out_ROB_index), 32'h33);
        end
        out_ready = 1;
        tick; clr;
        chk1("s4_in_ready_fire", in_ready, 1'b1);
        chk1("s4_ov_fire", out_valid, 1'b0);

        // flush while a response (ack) is arriving
        issue(1, 1, 7'h25, 0, 0, 7'h00, 7'h55);
        tick; clr;
        chk1("s5_req_c1", reg_read_req_valid_A, 1'b1);
        tick; clr;
        reg_read_ack_A = 1; reg_read_port_A = 1; flush = 1;
        tick; clr;
        chk1("s5_in_ready", in_ready, 1'b1);
        chk1("s5_ov_c3", out_valid, 1'b0);
        chk1("s5_req_c3", reg_read_req_valid_A, 1'b0);
        tick;
        chk1("s5_ov_c4", out_valid, 1'b0);
        chk1("s5_req_c4", reg_read_req_valid_A, 1'b0);
        issue(0, 0, 7'h00, 0, 0, 7'h00, 7'h56);
        flush = 1;
        tick; clr;
        chk1("s5_flush_accept_ov", out_valid, 1'b0);
        chk1("s5_flush_accept_rdy", in_ready, 1'b1);

        // reset mid-collect, then a late ack and a matching bus beat
        issue(1, 1, 7'h25, 1, 0, 7'h13, 7'h66);
        tick; clr;
        chk1("s6_req_c1", reg_read_req_valid_A, 1'b1);
        tick; clr;
        nRST = 0;
        tick; clr;
        nRST = 1;
        chk1("s6_in_ready", in_ready, 1'b1);
        chk1("s6_ov", out_valid, 1'b0);
        chk("s6_A_cleared", out_A_data, 0);
        reg_read_ack_A = 1; reg_read_port_A = 1; wbv[3] = 1; wbu[3] = 5'h04;
        tick; clr;
        chk1("s6_ov_late", out_valid, 1'b0);
        chk1("s6_req_late", reg_read_req_valid_A, 1'b0);
        chk1("s6_in_ready_late", in_ready, 1'b1);

        // randomized traffic against the event-level model
        m_busy = 0; m_out = 0; m_need = 0; m_rdy = 0; m_got = 0; m_req = 0; m_resp = 0;
        m_pr = 0; m_val = 0; m_rob = 0;
        for (int c = 0; c < 3000; c++) begin
            chk1("rnd_in_ready", in_ready, !m_busy);
            chk1("rnd_out_valid", out_valid, m_out);
            chk1("rnd_req_A", reg_read_req_valid_A, m_req[0]);
            chk1("rnd_req_B", reg_read_req_valid_B, m_req[1]);
            if (m_req[0]) chk("rnd_req_PR_A", 32'(reg_read_req_PR_A), 32'(m_pr[0]));
            if (m_req[1]) chk("rnd_req_PR_B", 32'(reg_read_req_PR_B), 32'(m_pr[1]));
            if (m_out) begin
                chk("rnd_out_A", out_A_data, m_val[0]);
                chk("rnd_out_B", out_B_data, m_val[1]);
                chk("rnd_out_rob", 32'(out_ROB_index), 32'(m_rob));
            end
            in_valid = 1'($urandom_range(0, 1));
            in_A_needed = ($urandom_range(0, 3) != 0);
            in_B_needed = ($urandom_range(0, 3) != 0);
            in_A_ready = 1'($urandom_range(0, 1));
            in_B_ready = 1'($urandom_range(0, 1));
            in_A_PR = 7'($urandom); in_B_PR = 7'($urandom); in_ROB_index = 7'($urandom);
            reg_read_ack_A = ($urandom_range(0, 9) < 6);
            reg_read_ack_B = ($urandom_range(0, 9) < 6);
            reg_read_port_A = 1'($urandom_range(0, 1));
            reg_read_port_B = 1'($urandom_range(0, 1));
            for (int b = 0; b < 4; b++) begin
                rd[b][0] = $urandom; rd[b][1] = $urandom;
                wbd[b] = $urandom; wbu[b] = 5'($urandom);
                wbv[b] = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 2) == 0) begin
                sel = 1'($urandom_range(0, 1));
                p = m_busy ? m_pr[sel] : (sel ? in_B_PR : in_A_PR);
                wbv[p[1:0]] = 1; wbu[p[1:0]] = p[6:2];
            end
            out_ready = ($urandom_range(0, 9) < 6);
            flush = ($urandom_range(0, 39) == 0);
            ack = {reg_read_ack_B, reg_read_ack_A};
            port = {reg_read_port_B, reg_read_port_A};
            if (flush) begin
                m_busy = 0; m_out = 0; m_req = 0; m_resp = 0;
            end else if (!m_busy) begin
                if (in_valid) begin
                    m_need = {in_B_needed, in_A_needed};
                    m_rdy = {in_B_ready, in_A_ready};
                    m_pr = {in_B_PR, in_A_PR};
                    m_rob = in_ROB_index;
                    for (int x = 0; x < 2; x++) begin
                        m_got[x] = !m_need[x] || (!m_rdy[x] && hit(m_pr[x]));
                        m_val[x] = !m_need[x] ? 32'h0 : wbd[m_pr[x][1:0]];
                        m_req[x] = m_need[x] && m_rdy[x];
                        m_resp[x] = 0;
                    end
                    m_busy = 1;
                    m_out = &m_got;
                end
            end else if (m_out) begin
                if (out_ready) begin m_busy = 0; m_out = 0; end
            end else begin
                for (int x = 0; x < 2; x++) begin
                    if (m_need[x] && !m_got[x] && !m_rdy[x] && hit(m_pr[x])) begin
                        m_got[x] = 1; m_val[x] = wbd[m_pr[x][1:0]];
                    end
                    if (m_resp[x] && ack[x]) begin
                        m_got[x] = 1; m_val[x] = rd[m_pr[x][1:0]][port[x]];
                    end
                    nreq = m_resp[x] && !ack[x];
                    m_resp[x] = m_req[x];
                    m_req[x] = nreq;
                end
                m_out = &m_got;
            end
            tick;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
